instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/risc_v_pipeline_pkg.sv | 17 +
 rtl/fetch_queue.sv | 58 +++++
 rtl/instruction_fetch.sv | 89 ++++++++
 3 files changed

// File: rtl/risc_v_pipeline_pkg.sv
// risc_v_pipeline_pkg: shared constants and types for the instruction fetch stage
package risc_v_pipeline_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetched {inst, pc} entries with flush
module fetch_queue
    import risc_v_pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign inst_o  = mem_q[rd_q].inst;
    assign pc_o    = mem_q[rd_q].pc;

    // pointer and occupancy update; a flush empties the queue regardless of push/pop
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        cnt_d   = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= '{inst: inst_i, pc: pc_i};
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch unit with redirect and decoupling queue.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetching and raise misalign_o.
module instruction_fetch
    import risc_v_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, target;
    logic         misalign_q, misalign_d;
    logic         granted, push, pop, full, empty;
    logic [31:0]  q_inst, q_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc_i;
    assign misalign_d = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : misalign_q;
`else
    assign target     = redirect_pc_i & ~32'h3;
    assign misalign_d = 1'b0;
`endif

    assign imem_req_o  = rst_ni && state_q == S_IDLE && !full && !misalign_q;
    assign imem_addr_o = pc_q;
    assign granted     = imem_req_o && imem_gnt_i;
    assign push        = state_q == S_WAIT && imem_rvalid_i && !redirect_i;
    assign pop         = !empty && !stall_i && !redirect_i;
    assign valid_o     = !empty;
    assign inst_o      = empty ? NOP : q_inst;
    assign pc_o        = empty ? 32'h0 : q_pc;
    assign misalign_o  = misalign_q;

    // next fetch PC and request/response tracking FSM
    always_comb begin
        state_d = state_q;
        pc_d    = redirect_i ? target : pc_q + (granted ? 32'd4 : 32'd0);
        unique case (state_q)
            S_IDLE:  if (granted) state_d = redirect_i ? S_DROP : S_WAIT;
            S_WAIT:  if (imem_rvalid_i) state_d = S_IDLE;
                     else if (redirect_i) state_d = S_DROP;
            S_DROP:  if (imem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state, fetch PC and misalignment flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // the pending request's address is pc_q - 4 because pc_q only moves on grant or redirect
    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .inst_i  (imem_rdata_i),
        .pc_i    (pc_q - 32'd4),
        .inst_o  (q_inst),
        .pc_o    (q_pc),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
